load_store_unit: RTL and testbench

Initiator side of the data memory interface. Accepts one load or store request at a time from the MIPS pipeline's MEM stage and drives the word-wide synchronous data memory (`we`, `address`, `data_in` in; registered `data_out`). Handles byte and halfword accesses: loads use sign or zero extraction, sub-word stores use read-modify-write. Byte order is big-endian, so byte offset 0 is bits [31:24].

---
 rtl/mips_mem_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 23 ++
 rtl/lsu_byte_lane.sv | 47 ++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory initiator: access size codes,
// LSU state encoding and big-endian lane positions.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  // Big-endian: byte offset 0 and half 0 sit in the most significant lanes.
  localparam logic [4:0] BYTE0_LSB = 5'd24;
  localparam logic [4:0] HALF0_LSB = 5'd16;

  function automatic logic [4:0] byte_lsb(input logic [1:0] offset);
    return BYTE0_LSB - {offset, 3'b000};
  endfunction

  function automatic logic [4:0] half_lsb(input logic half_sel);
    return half_sel ? 5'd0 : HALF0_LSB;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response channel of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational big-endian lane logic: load extraction/extension and
// sub-word store merge into a full memory word.
module lsu_byte_lane
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  b_lsb;
  logic [4:0]  h_lsb;
  logic [7:0]  b_val;
  logic [15:0] h_val;

  assign b_lsb = byte_lsb(offset);
  assign h_lsb = half_lsb(offset[1]);
  assign b_val = word[b_lsb +: 8];
  assign h_val = word[h_lsb +: 16];

  // Load extraction with sign or zero extension.
  always_comb begin
    load_data = 32'h0000_0000;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h000000, b_val} : {{24{b_val[7]}}, b_val};
      SIZE_HALF: load_data = is_unsigned ? {16'h0000, h_val} : {{16{h_val[15]}}, h_val};
      SIZE_WORD: load_data = word;
      default:   load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: only the low byte/half of wdata lands in the addressed lane.
  always_comb begin
    merged = word;
    case (size)
      SIZE_BYTE: merged = (word & ~(32'h0000_00FF << b_lsb)) | ((wdata & 32'h0000_00FF) << b_lsb);
      SIZE_HALF: merged = (word & ~(32'h0000_FFFF << h_lsb)) | ((wdata & 32'h0000_FFFF) << h_lsb);
      SIZE_WORD: merged = wdata;
      default:   merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide synchronous data memory.
// Optional build macro LSU_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDRESS_SZ = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  load_store_unit_if.slave      lsu,
  output logic                  mem_we,
  output logic [ADDRESS_SZ-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_rdata
);

  lsu_state_e state_r, next_state_s;

  logic                  cap_write_r, cap_write_s;
  logic [1:0]            cap_size_r, cap_size_s;
  logic                  cap_unsigned_r, cap_unsigned_s;
  logic [1:0]            cap_offset_r, cap_offset_s;
  logic [31:0]           cap_wdata_r, cap_wdata_s;

  logic                  mem_we_r, mem_we_s;
  logic [ADDRESS_SZ-1:0] mem_address_r, mem_address_s;
  logic [31:0]           mem_data_in_r, mem_data_in_s;
  logic                  req_ready_r;
  logic                  resp_valid_r, resp_valid_s;
  logic [31:0]           resp_rdata_r, resp_rdata_s;
  logic                  resp_err_r, resp_err_s;

  logic                  req_err_s;
  logic                  misalign_s;
  logic [31:0]           load_data_s;
  logic [31:0]           merged_s;
  logic [31-ADDRESS_SZ-2:0] unused_addr_hi;

  assign unused_addr_hi = lsu.req_addr[31:ADDRESS_SZ+2];

  lsu_byte_lane u_lane (
    .word        (mem_rdata),
    .offset      (cap_offset_r),
    .size        (cap_size_r),
    .is_unsigned (cap_unsigned_r),
    .wdata       (cap_wdata_r),
    .load_data   (load_data_s),
    .merged      (merged_s)
  );

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_s = ((lsu.req_size == SIZE_HALF) && lsu.req_addr[0]) ||
                      ((lsu.req_size == SIZE_WORD) && (lsu.req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign req_err_s = (lsu.req_size == SIZE_RSVD) || misalign_s;

  // Next-state and next registered-output logic.
  always_comb begin
    next_state_s   = state_r;
    cap_write_s    = cap_write_r;
    cap_size_s     = cap_size_r;
    cap_unsigned_s = cap_unsigned_r;
    cap_offset_s   = cap_offset_r;
    cap_wdata_s    = cap_wdata_r;
    mem_we_s       = 1'b0;
    mem_address_s  = mem_address_r;
    mem_data_in_s  = mem_data_in_r;
    resp_valid_s   = 1'b0;
    resp_rdata_s   = resp_rdata_r;
    resp_err_s     = resp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (lsu.req_valid && req_ready_r) begin
          cap_write_s    = lsu.req_write;
          cap_size_s     = lsu.req_size;
          cap_unsigned_s = lsu.req_unsigned;
          cap_offset_s   = lsu.req_addr[1:0];
          cap_wdata_s    = lsu.req_wdata;
          resp_rdata_s   = 32'h0000_0000;
          resp_err_s     = 1'b0;
          if (req_err_s) begin
            next_state_s = ST_RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else if (lsu.req_write && (lsu.req_size == SIZE_WORD)) begin
            next_state_s  = ST_WR;
            mem_we_s      = 1'b1;
            mem_address_s = lsu.req_addr[ADDRESS_SZ+1:2];
            mem_data_in_s = lsu.req_wdata;
          end else begin
            next_state_s  = ST_RD;
            mem_address_s = lsu.req_addr[ADDRESS_SZ+1:2];
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD: next_state_s = ST_RD_DATA;
      ST_RD_DATA: begin
        if (cap_write_r) begin
          next_state_s  = ST_WR;
          mem_we_s      = 1'b1;
          mem_data_in_s = merged_s;
        end else begin
          next_state_s = ST_RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = load_data_s;
        end
      end
      ST_WR: begin
        next_state_s = ST_RESP;
        resp_valid_s = 1'b1;
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cap_write_r    <= 1'b0;
      cap_size_r     <= SIZE_BYTE;
      cap_unsigned_r <= 1'b0;
      cap_offset_r   <= 2'b00;
      cap_wdata_r    <= 32'h0000_0000;
      mem_we_r       <= 1'b0;
      mem_address_r  <= '0;
      mem_data_in_r  <= 32'h0000_0000;
      req_ready_r    <= 1'b1;
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= 32'h0000_0000;
      resp_err_r     <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      cap_write_r    <= cap_write_s;
      cap_size_r     <= cap_size_s;
      cap_unsigned_r <= cap_unsigned_s;
      cap_offset_r   <= cap_offset_s;
      cap_wdata_r    <= cap_wdata_s;
      mem_we_r       <= mem_we_s;
      mem_address_r  <= mem_address_s;
      mem_data_in_r  <= mem_data_in_s;
      req_ready_r    <= (next_state_s == ST_IDLE);
      resp_valid_r   <= resp_valid_s;
      resp_rdata_r   <= resp_rdata_s;
      resp_err_r     <= resp_err_s;
    end
  end

  assign mem_we          = mem_we_r;
  assign mem_address     = mem_address_r;
  assign mem_data_in     = mem_data_in_r;
  assign lsu.req_ready   = req_ready_r;
  assign lsu.resp_valid  = resp_valid_r;
  assign lsu.resp_rdata  = resp_rdata_r;
  assign lsu.resp_err    = resp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural synchronous data memory.
module tb_load_store_unit;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we;
  logic [9:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_rdata;
  logic [31:0] ram [0:1023];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] rdata; logic err; int lat; int issued; } resp_t;
  typedef struct { logic [9:0] addr; logic [31:0] data; int lat; int issued; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  load_store_unit_if lsu_i ();

  load_store_unit #(.ADDRESS_SZ(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu         (lsu_i),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: write-first not needed, registered read data.
  always @(posedge clk) begin
    if (mem_we) ram[mem_address] <= mem_data_in;
    mem_rdata <= ram[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && lsu_i.resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_rdata", lsu_i.resp_rdata, e.rdata);
        chk("resp_err", {31'd0, lsu_i.resp_err}, {31'd0, e.err});
        chk("resp_latency", cyc - e.issued, e.lat);
      end
    end
  end

  // Memory write monitor.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_address", {22'd0, mem_address}, {22'd0, w.addr});
        chk("wr_data", mem_data_in, w.data);
        chk("wr_latency", cyc - w.issued, w.lat);
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int resp_lat, input int ready_lat,
                       input logic exp_wr, input logic [31:0] exp_wdata, input int wr_lat,
                       input logic [9:0] exp_maddr);
    int n;
    int issued;
    n = 0;
    while (!lsu_i.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!lsu_i.req_ready) chk("ready_timeout", 32'd0, 32'd1);
    lsu_i.req_valid    = 1'b1;
    lsu_i.req_write    = w;
    lsu_i.req_size     = sz;
    lsu_i.req_unsigned = u;
    lsu_i.req_addr     = a;
    lsu_i.req_wdata    = wd;
    issued = cyc;
    resp_q.push_back('{rdata: exp_rd, err: exp_err, lat: resp_lat, issued: issued});
    if (exp_wr) wr_q.push_back('{addr: exp_maddr, data: exp_wdata, lat: wr_lat, issued: issued});
    @(posedge clk);
    #1;
    lsu_i.req_valid = 1'b0;
    lsu_i.req_write = ~w;
    lsu_i.req_size  = 2'b11;
    lsu_i.req_addr  = 32'hFFFF_FFFF;
    lsu_i.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (!exp_err) chk("mem_address", {22'd0, mem_address}, {22'd0, exp_maddr});
    n = 1;
    while (!lsu_i.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_latency", cyc - issued, ready_lat);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0000_0000;
    lsu_i.req_valid    = 1'b0;
    lsu_i.req_write    = 1'b0;
    lsu_i.req_size     = SIZE_WORD;
    lsu_i.req_unsigned = 1'b0;
    lsu_i.req_addr     = 32'h0000_0000;
    lsu_i.req_wdata    = 32'h0000_0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, lsu_i.req_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_address", {22'd0, mem_address}, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_resp_valid", {31'd0, lsu_i.resp_valid}, 32'd0);
    chk("rst_resp_rdata", lsu_i.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, lsu_i.resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // w sz u addr wdata | exp_rd err resp_lat ready_lat | wr wdata wr_lat | maddr
    issue(1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hAABBCCDD, 32'h0, 1'b0, 2, 3, 1'b1, 32'hAABBCCDD, 1, 10'd0);
    issue(1'b0, SIZE_BYTE, 1'b0, 32'h1, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h1, 32'h0, 32'h000000BB, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b0, SIZE_HALF, 1'b0, 32'h2, 32'h0, 32'hFFFFCCDD, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b0, SIZE_HALF, 1'b1, 32'h0, 32'h0, 32'h0000AABB, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h3, 32'h12345611, 32'h0, 1'b0, 4, 5, 1'b1, 32'hAABBCC11, 3, 10'd0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'hAABBCC11, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b1, SIZE_HALF, 1'b0, 32'h1, 32'h5566, 32'h0, 1'b1, 1, 2, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'hAABBCC11, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b1, SIZE_HALF, 1'b0, 32'h0, 32'h5566, 32'h0, 1'b0, 4, 5, 1'b1, 32'h5566CC11, 3, 10'd0);
`else
    issue(1'b1, SIZE_HALF, 1'b0, 32'h1, 32'h5566, 32'h0, 1'b0, 4, 5, 1'b1, 32'h5566CC11, 3, 10'd0);
`endif
    issue(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'h5566CC11, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 32'h5566CC11, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, 1, 2, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h8, 32'h1234, 32'h0, 1'b1, 1, 2, 1'b0, 32'h0, 0, 10'd0);
    issue(1'b1, SIZE_WORD, 1'b0, 32'h8, 32'h80FF0102, 32'h0, 1'b0, 2, 3, 1'b1, 32'h80FF0102, 1, 10'd2);
    issue(1'b0, SIZE_BYTE, 1'b0, 32'hA, 32'h0, 32'h00000001, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd2);
    issue(1'b0, SIZE_HALF, 1'b0, 32'h8, 32'h0, 32'hFFFF80FF, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd2);
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h8, 32'hFFFFFF99, 32'h0, 1'b0, 4, 5, 1'b1, 32'h99FF0102, 3, 10'd2);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, 32'h99FF0102, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd2);

    // Reset during the WR cycle of a sub-word store.
    lsu_i.req_valid    = 1'b1;
    lsu_i.req_write    = 1'b1;
    lsu_i.req_size     = SIZE_BYTE;
    lsu_i.req_unsigned = 1'b0;
    lsu_i.req_addr     = 32'h8;
    lsu_i.req_wdata    = 32'h77;
    @(posedge clk);
    #1;
    lsu_i.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_abort_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_abort_we_after", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rst_abort_resp_valid", {31'd0, lsu_i.resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_req_ready", {31'd0, lsu_i.req_ready}, 32'd1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, 32'h99FF0102, 1'b0, 3, 4, 1'b0, 32'h0, 0, 10'd2);

    repeat (4) @(negedge clk);
    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
